// File: rtl/ifmap_feeder.sv
// Streams a row-major ifmap tile from the global buffer into PE FIFO beats of PAR_WRITE lanes.
// Define IFMAP_FEEDER_STALL_CNT_EN to build the saturating push-stall counter.
module ifmap_feeder #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PAR_WRITE     = 2,
  parameter int unsigned ADDR_WIDTH_GB = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH_GB-1:0]            base_addr,
  input  logic [7:0]                          row_len,
  input  logic [7:0]                          num_rows,
  output logic                                gb_ren,
  output logic [ADDR_WIDTH_GB-1:0]            gb_raddr,
  input  logic [DATA_WIDTH-1:0]               gb_rdata,
  input  logic                                ready_ifm,
  output logic                                w_en_ifm,
  output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0] data_in_ifm,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         stall_cycles
);

  localparam int unsigned LaneW = DATA_WIDTH + 2;
  localparam int unsigned CntW  = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(PAR_WRITE - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StCapture = 3'd2,
    StPush    = 3'd3,
    StFinish  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH_GB-1:0] base_q;
  logic [ADDR_WIDTH_GB-1:0] idx_q;
  logic [7:0]               row_len_q, num_rows_q;
  logic [7:0]               col_q, row_q;
  logic [CntW-1:0]          lane_q;
  logic                     last_q;
  logic [LaneW-1:0]         beat_q [PAR_WRITE];

  logic is_eor, is_last;

  assign is_eor  = (col_q == row_len_q - 8'd1);
  assign is_last = is_eor && (row_q == num_rows_q - 8'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = StCapture;
      StCapture: state_d = (lane_q == LastLane || is_last) ? StPush : StFetch;
      StPush:    if (ready_ifm) state_d = last_q ? StFinish : StFetch;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    data_in_ifm = '0;
    for (int k = 0; k < int'(PAR_WRITE); k++) begin
      data_in_ifm[k*LaneW +: LaneW] = beat_q[k];
    end
  end

  assign gb_ren   = (state_q == StFetch);
  assign gb_raddr = (state_q == StFetch) ? base_q + idx_q : '0;
  assign w_en_ifm = (state_q == StPush) && ready_ifm;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFinish);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      idx_q      <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      last_q     <= 1'b0;
      for (int k = 0; k < int'(PAR_WRITE); k++) beat_q[k] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q     <= base_addr;
            row_len_q  <= row_len;
            num_rows_q <= num_rows;
            idx_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            lane_q     <= '0;
            last_q     <= 1'b0;
            for (int k = 0; k < int'(PAR_WRITE); k++) beat_q[k] <= '0;
          end
        end
        StCapture: begin
          beat_q[lane_q] <= {is_last, is_eor, gb_rdata};
          // Lanes past the final element carry eos so the PE sees stream end in every lane.
          for (int k = 0; k < int'(PAR_WRITE); k++) begin
            if (is_last && k > int'(lane_q)) beat_q[k] <= {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
          end
          idx_q  <= idx_q + 1'b1;
          last_q <= is_last;
          lane_q <= (lane_q == LastLane) ? '0 : lane_q + 1'b1;
          if (is_eor) begin
            col_q <= '0;
            row_q <= row_q + 8'd1;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
        StPush: begin
          if (ready_ifm) begin
            lane_q <= '0;
            for (int k = 0; k < int'(PAR_WRITE); k++) beat_q[k] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFMAP_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start) begin
      stall_q <= '0;
    end else if (state_q == StPush && !ready_ifm && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_ifmap_feeder.sv
// Directed bench for ifmap_feeder: latency, packing, padding, stalls, reset and address wrap.
module tb_ifmap_feeder;

  localparam int DW = 8;
  localparam int PW = 2;
  localparam int AW = 8;
  localparam int LW = DW + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [7:0]        row_len, num_rows;
  logic              gb_ren;
  logic [AW-1:0]     gb_raddr;
  logic [DW-1:0]     gb_rdata;
  logic              ready_ifm;
  logic              w_en_ifm;
  logic [PW*LW-1:0]  data_in_ifm;
  logic              busy, done;
  logic [15:0]       stall_cycles;

  ifmap_feeder #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .ADDR_WIDTH_GB(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows), .gb_ren(gb_ren), .gb_raddr(gb_raddr), .gb_rdata(gb_rdata),
    .ready_ifm(ready_ifm), .w_en_ifm(w_en_ifm), .data_in_ifm(data_in_ifm), .busy(busy),
    .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) if (gb_ren) gb_rdata <= mem[gb_raddr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 1000000;

  logic [PW*LW-1:0] beats[$];
  int               beat_cyc[$];
  logic [AW-1:0]    raddrs[$];
  int               done_cyc[$];
  logic [PW*LW-1:0] hist [64];
  logic             busy_hist [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int rel;
    #1;
    rel = cyc - t0;
    if (rel >= 0 && rel < 64) begin
      hist[rel]      = data_in_ifm;
      busy_hist[rel] = busy;
    end
    if (w_en_ifm) begin
      beats.push_back(data_in_ifm);
      beat_cyc.push_back(rel);
    end
    if (gb_ren) raddrs.push_back(gb_raddr);
    if (done) done_cyc.push_back(rel);
  end

  function automatic logic [LW-1:0] ln(input logic eos, input logic eor, input logic [DW-1:0] d);
    return {eos, eor, d};
  endfunction

  // Launches a tile and runs 40 cycles; ready drops for `hold` cycles from rel 5,
  // extra start pulses at rel sa/sb, rst pulse at rel ra (-1 disables).
  task automatic drive_tile(input logic [AW-1:0] b, input logic [7:0] rl, input logic [7:0] nr,
                            input int hold, input int sa, input int sb, input int ra);
    @(negedge clk);
    beats.delete(); beat_cyc.delete(); raddrs.delete(); done_cyc.delete();
    base_addr = b; row_len = rl; num_rows = nr; start = 1'b1; ready_ifm = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel < 40; rel++) begin
      @(negedge clk);
      start     = (rel == sa || rel == sb);
      ready_ifm = !(rel >= 5 && rel < 5 + hold);
      rst       = (rel == ra);
      base_addr = 8'hAA; row_len = 8'd7; num_rows = 8'd7;
    end
    start = 1'b0; ready_ifm = 1'b1; rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready_ifm = 1'b1; base_addr = '0; row_len = 8'd1; num_rows = 8'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (gb_ren !== 1'b0 || gb_raddr !== 8'h00) begin
      bad++; $display("FAIL reset_gb got=%b/%h want=0/00", gb_ren, gb_raddr); end
    total++; if (w_en_ifm !== 1'b0 || data_in_ifm !== '0) begin
      bad++; $display("FAIL reset_push got=%b/%h want=0/0", w_en_ifm, data_in_ifm); end
    total++; if (stall_cycles !== 16'h0) begin
      bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_basic;
    logic [PW*LW-1:0] e0, e1;
    mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;
    e0 = {ln(0, 1, 8'd2), ln(0, 0, 8'd1)};
    e1 = {ln(1, 1, 8'd4), ln(0, 0, 8'd3)};
    drive_tile(8'h10, 8'd2, 8'd2, 0, -1, -1, -1);
    total++; if (beats.size() != 2) begin
      bad++; $display("FAIL basic_count got=%0d want=2", beats.size());
    end else begin
      total++; if (beats[0] !== e0) begin bad++; $display("FAIL basic_beat0 got=%h want=%h", beats[0], e0); end
      total++; if (beats[1] !== e1) begin bad++; $display("FAIL basic_beat1 got=%h want=%h", beats[1], e1); end
      total++; if (beat_cyc[0] != 5) begin
        bad++; $display("FAIL basic_first_wen got=%0d want=5", beat_cyc[0]); end
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      bad++; $display("FAIL basic_done got=%0d pulses first=%0d want=1 at 11", done_cyc.size(),
                      (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    total++; if (raddrs.size() != 4 || raddrs[0] !== 8'h10 || raddrs[3] !== 8'h13) begin
      bad++; $display("FAIL basic_raddr got=%0d reads want=4 from 10..13", raddrs.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_partial;
    logic [PW*LW-1:0] e0, e1;
    mem[8'h20] = 8'd5; mem[8'h21] = 8'd6; mem[8'h22] = 8'd7;
    e0 = {ln(0, 0, 8'd6), ln(0, 0, 8'd5)};
    e1 = {ln(1, 0, 8'd0), ln(1, 1, 8'd7)};
    drive_tile(8'h20, 8'd3, 8'd1, 0, -1, -1, -1);
    total++; if (beats.size() != 2) begin
      bad++; $display("FAIL partial_count got=%0d want=2", beats.size());
    end else begin
      total++; if (beats[0] !== e0) begin bad++; $display("FAIL partial_beat0 got=%h want=%h", beats[0], e0); end
      total++; if (beats[1] !== e1) begin bad++; $display("FAIL partial_pad got=%h want=%h", beats[1], e1); end
    end
    total++; if (done_cyc.size() != 1) begin
      bad++; $display("FAIL partial_done got=%0d want=1", done_cyc.size()); end
  endtask

  task automatic test_stall;
    logic [PW*LW-1:0] e0;
    logic [15:0] want;
    e0 = {ln(0, 1, 8'd2), ln(0, 0, 8'd1)};
`ifdef IFMAP_FEEDER_STALL_CNT_EN
    want = 16'd4;
`else
    want = 16'd0;
`endif
    drive_tile(8'h10, 8'd2, 8'd2, 4, -1, -1, -1);
    for (int r = 5; r < 9; r++) begin
      total++; if (hist[r] !== e0) begin
        bad++; $display("FAIL stall_hold rel=%0d got=%h want=%h", r, hist[r], e0); end
    end
    total++; if (beat_cyc.size() != 2 || beat_cyc[0] != 9) begin
      bad++; $display("FAIL stall_first_wen got=%0d want=9",
                      (beat_cyc.size() > 0) ? beat_cyc[0] : -1); end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != 15) begin
      bad++; $display("FAIL stall_done got=%0d want=15",
                      (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    total++; if (stall_cycles !== want) begin
      bad++; $display("FAIL stall_count got=%0d want=%0d", stall_cycles, want); end
    drive_tile(8'h10, 8'd2, 8'd2, 0, -1, -1, -1);
    total++; if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL stall_clear got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_reset_mid;
    drive_tile(8'h10, 8'd2, 8'd2, 0, -1, -1, 4);
    total++; if (busy_hist[5] !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy got=%b want=0", busy_hist[5]); end
    total++; if (beats.size() != 0 || done_cyc.size() != 0) begin
      bad++; $display("FAIL rstmid_quiet got=%0d beats %0d done want=0/0", beats.size(),
                      done_cyc.size()); end
  endtask

  task automatic test_ignore_start;
    logic [PW*LW-1:0] e0, e1;
    e0 = {ln(0, 1, 8'd2), ln(0, 0, 8'd1)};
    e1 = {ln(1, 1, 8'd4), ln(0, 0, 8'd3)};
    drive_tile(8'h10, 8'd2, 8'd2, 0, 3, 7, -1);
    total++; if (beats.size() != 2 || beats[0] !== e0 || beats[1] !== e1) begin
      bad++; $display("FAIL ignore_stream got=%0d beats want=2 identical", beats.size()); end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      bad++; $display("FAIL ignore_done got=%0d want=11",
                      (done_cyc.size() > 0) ? done_cyc[0] : -1); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] want [4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    drive_tile(8'hFE, 8'd2, 8'd2, 0, -1, -1, -1);
    total++; if (raddrs.size() != 4) begin
      bad++; $display("FAIL wrap_count got=%0d want=4", raddrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (raddrs[i] !== want[i]) begin
          bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, raddrs[i], want[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'hFE] = 8'd9; mem[8'hFF] = 8'd8; mem[8'h00] = 8'd7; mem[8'h01] = 8'd6;
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_reset_mid();
    test_ignore_start();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
